// File: rtl/raster_pixel_source_if.sv
// Frame RAM port, start request and streamed-pixel outputs of raster_pixel_source.
// The master modport is the source; the slave modport is the RAM and consumer side.
interface raster_pixel_source_if #(
  parameter int unsigned SIZE_WORD = 8,
  parameter int unsigned ADDR_W    = 7
);
  logic                 start;
  logic                 mem_rd;
  logic [ADDR_W-1:0]    mem_addr;
  logic [SIZE_WORD-1:0] mem_data;
  logic [SIZE_WORD-1:0] outputPixel;
  logic                 pixel_valid;
  logic                 sof;
  logic                 eol;
  logic                 busy;
  logic                 done;

  modport master (
    input  start, mem_data,
    output mem_rd, mem_addr, outputPixel, pixel_valid, sof, eol, busy, done
  );

  modport slave (
    output start, mem_data,
    input  mem_rd, mem_addr, outputPixel, pixel_valid, sof, eol, busy, done
  );
endinterface

// File: rtl/raster_pixel_source.sv
// Streams one HTOT x VTOT frame from a sync-read RAM in raster order, then FLUSH_LINES zero lines.
// Define TEST_PATTERN_EN to replace RAM data with an (x + y) ramp and leave mem_rd low.
module raster_pixel_source #(
  parameter int unsigned SIZE_WORD   = 8,
  parameter int unsigned HTOT        = 10,
  parameter int unsigned VTOT        = 8,
  parameter int unsigned FLUSH_LINES = 2,
  parameter int unsigned ADDR_W      = $clog2(HTOT * VTOT)
) (
  input logic                   clock,
  input logic                   reset,
  raster_pixel_source_if.master bus
);
  localparam int unsigned NPIX = HTOT * VTOT;
  localparam int unsigned YTOT = VTOT + FLUSH_LINES;
  localparam int unsigned XW   = $clog2(HTOT + 1);
  localparam int unsigned YW   = $clog2(YTOT + 1);

  typedef enum logic [1:0] {StIdle, StRead, StFlush, StDrain} state_e;

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                done_d;

  // Stage 1: aligned with RAM read data; stage 2: registered outputs.
  logic                v1_q, sof1_q, eol1_q, zero1_q;
  logic                valid_q, sof_q, eol_q, done_q;
  logic [SIZE_WORD-1:0] pixel_q, pixel_d, frame_pix;

  logic issue, last_x;
  assign issue  = (state_q == StRead) || (state_q == StFlush);
  assign last_x = (x_q == XW'(HTOT - 1));

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    done_d  = 1'b0;
    if (issue) begin
      if (last_x) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    unique case (state_q)
      StIdle: begin
        x_d    = '0;
        y_d    = '0;
        addr_d = '0;
        if (bus.start) state_d = StRead;
      end
      StRead: begin
        addr_d = addr_q + 1'b1;
        if (addr_q == ADDR_W'(NPIX - 1)) begin
          addr_d  = '0;
          state_d = (FLUSH_LINES == 0) ? StDrain : StFlush;
        end
      end
      StFlush: begin
        if (last_x && (y_q == YW'(YTOT - 1))) state_d = StDrain;
      end
      StDrain: begin
        x_d = '0;
        y_d = '0;
        // Leave once the last issued slot has moved into the output register.
        if (!v1_q) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef TEST_PATTERN_EN
  logic [SIZE_WORD-1:0] pat1_q;
  logic                 unused_mem_data;
  assign unused_mem_data = ^bus.mem_data;
  assign frame_pix       = pat1_q;
  assign bus.mem_rd      = 1'b0;

  always_ff @(posedge clock) begin
    if (reset) pat1_q <= '0;
    else       pat1_q <= SIZE_WORD'(x_q) + SIZE_WORD'(y_q);
  end
`else
  assign frame_pix  = bus.mem_data;
  assign bus.mem_rd = (state_q == StRead);
`endif

  assign pixel_d = (v1_q && !zero1_q) ? frame_pix : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      v1_q    <= 1'b0;
      sof1_q  <= 1'b0;
      eol1_q  <= 1'b0;
      zero1_q <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      pixel_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      v1_q    <= issue;
      sof1_q  <= (state_q == StRead) && (addr_q == '0);
      eol1_q  <= issue && last_x;
      zero1_q <= (state_q == StFlush);
      valid_q <= v1_q;
      sof_q   <= sof1_q;
      eol_q   <= eol1_q;
      pixel_q <= pixel_d;
      done_q  <= done_d;
    end
  end

  assign bus.mem_addr    = (state_q == StRead) ? addr_q : '0;
  assign bus.outputPixel = pixel_q;
  assign bus.pixel_valid = valid_q;
  assign bus.sof         = sof_q;
  assign bus.eol         = eol_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.done        = done_q;
endmodule
